// File: rtl/board_loader.sv
// board_loader: sequences LOAD (host digits -> grid cells) and DUMP
// (grid cells -> host digits) over the shared cell cmd/data bus.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for load_start / dump_start
// LOAD    | accepting host digits, one write strobe per accepted beat
// RD_REQ  | read command (0001) on the bus for the current cell
// RD_WAIT | cell data_out valid, captured into the output register
// RD_OUT  | output digit presented, waiting for the consumer to accept
module board_loader #(
  parameter int N_CELLS = 81,
  parameter int DW      = 4,
  parameter int AW      = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_start,
  input  logic          i_dump_start,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  output logic [AW-1:0] o_cell_sel,
  output logic [3:0]    o_cell_cmd,
  output logic [DW-1:0] o_cell_data,
  output logic          o_cell_data_rdy,
  input  logic [DW-1:0] i_cell_rdata,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [3:0]    CMD_WR    = 4'b0000;
  localparam logic [3:0]    CMD_RD    = 4'b0001;
  localparam logic [3:0]    CMD_NOP   = 4'b1111;
  localparam logic [AW-1:0] IDX_LAST  = AW'(N_CELLS - 1);
  localparam logic [DW-1:0] DIGIT_MAX = DW'(9);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_OUT  = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [AW-1:0] r_sel, w_sel_nxt;
  logic [3:0]    r_cmd, w_cmd_nxt;
  logic [DW-1:0] r_cdata, w_cdata_nxt;
  logic          r_cdrdy, w_cdrdy_nxt;
  logic          r_ov, w_ov_nxt;
  logic [DW-1:0] r_odata, w_odata_nxt;
  logic          r_olast, w_olast_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          w_digit_ok;

  assign w_digit_ok = (i_in_data <= DIGIT_MAX);

  // Next-state and next-output decode; the bus defaults to NOP every cycle
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sel_nxt   = r_sel;
    w_cmd_nxt   = CMD_NOP;
    w_cdata_nxt = r_cdata;
    w_cdrdy_nxt = 1'b0;
    w_ov_nxt    = r_ov;
    w_odata_nxt = r_odata;
    w_olast_nxt = r_olast;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_load_start) begin
          w_err_nxt   = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = S_LOAD;
        end else if (i_dump_start) begin
          w_idx_nxt   = '0;
          w_sel_nxt   = '0;
          w_cmd_nxt   = CMD_RD;
          w_state_nxt = S_RD_REQ;
        end
      end
      S_LOAD: begin
        if (i_in_valid) begin
          w_cdrdy_nxt = 1'b1;
          w_cmd_nxt   = CMD_WR;
          w_sel_nxt   = r_idx;
          w_cdata_nxt = w_digit_ok ? i_in_data : '0;
          if (!w_digit_ok) w_err_nxt = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + AW'(1);
          end
        end
      end
      S_RD_REQ: begin
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_odata_nxt = i_cell_rdata;
        w_olast_nxt = (r_idx == IDX_LAST);
        w_ov_nxt    = 1'b1;
        w_state_nxt = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (i_out_ready) begin
          w_ov_nxt = 1'b0;
          if (r_olast) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + AW'(1);
            w_sel_nxt   = r_idx + AW'(1);
            w_cmd_nxt   = CMD_RD;
            w_state_nxt = S_RD_REQ;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset also drops any write strobe in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sel   <= '0;
      r_cmd   <= CMD_NOP;
      r_cdata <= '0;
      r_cdrdy <= 1'b0;
      r_ov    <= 1'b0;
      r_odata <= '0;
      r_olast <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sel   <= w_sel_nxt;
      r_cmd   <= w_cmd_nxt;
      r_cdata <= w_cdata_nxt;
      r_cdrdy <= w_cdrdy_nxt;
      r_ov    <= w_ov_nxt;
      r_odata <= w_odata_nxt;
      r_olast <= w_olast_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_in_ready      = (r_state == S_LOAD);
  assign o_cell_sel      = r_sel;
  assign o_cell_cmd      = r_cmd;
  assign o_cell_data     = r_cdata;
  assign o_cell_data_rdy = r_cdrdy;
  assign o_out_valid     = r_ov;
  assign o_out_data      = r_odata;
  assign o_out_last      = r_olast;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;

endmodule

// File: tb/tb_board_loader.sv
// tb_board_loader: randomized LOAD/DUMP traffic against a transaction-level
// model of the loader, plus a simple grid-cell array model on the bus.
module tb_board_loader;

  localparam int N = 81;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       dump_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b0;
  logic [3:0] cell_rdata = 4'd0;

  logic       o_in_ready;
  logic [6:0] o_cell_sel;
  logic [3:0] o_cell_cmd;
  logic [3:0] o_cell_data;
  logic       o_cell_data_rdy;
  logic       o_out_valid;
  logic [3:0] o_out_data;
  logic       o_out_last;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  board_loader dut (
    .i_clk(clk), .i_rst(rst),
    .i_load_start(load_start), .i_dump_start(dump_start),
    .i_in_valid(in_valid), .o_in_ready(o_in_ready), .i_in_data(in_data),
    .o_cell_sel(o_cell_sel), .o_cell_cmd(o_cell_cmd),
    .o_cell_data(o_cell_data), .o_cell_data_rdy(o_cell_data_rdy),
    .i_cell_rdata(cell_rdata),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready),
    .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cell array: writes on strobe, registers data_out on a read command.
  // rd_mode=1 makes every cell answer with its own index+1 (mod 16).
  logic [3:0] cmem [0:N-1];
  bit         rd_mode = 1'b0;

  initial for (int i = 0; i < N; i++) cmem[i] = 4'd0;

  always @(posedge clk) begin
    if (o_cell_data_rdy && o_cell_cmd == 4'h0) cmem[o_cell_sel] <= o_cell_data;
    if (o_cell_cmd == 4'h1)
      cell_rdata <= rd_mode ? (o_cell_sel[3:0] + 4'd1) : cmem[o_cell_sel];
  end

  // Reference model: mode 0 idle, 1 load, 2 dump; a dump beat takes
  // three cycles (request, wait, present). e_* are expected outputs.
  int  m_mem [0:N-1];
  bit  m_valid = 1'b0;
  int  m_mode = 0;
  int  m_phase = 0;
  int  m_idx = 0;
  int  e_cmd = 15, e_sel = 0, e_cdata = 0, e_od = 0;
  bit  e_rdy = 0, e_ov = 0, e_ol = 0, e_done = 0, e_err = 0, e_busy = 0;
  bit  e_after_rst = 0;

  int  n_strobe = 0, n_rd = 0, n_done = 0;

  initial for (int i = 0; i < N; i++) m_mem[i] = 0;

  function automatic int rd_value(input int idx);
    return rd_mode ? ((idx + 1) % 16) : m_mem[idx];
  endfunction

  task automatic model_step();
    int d;
    e_after_rst = 1'b0;
    if (rst) begin
      m_valid = 1'b1; m_mode = 0; m_idx = 0; m_phase = 0;
      e_cmd = 15; e_rdy = 0; e_sel = 0; e_cdata = 0;
      e_ov = 0; e_od = 0; e_ol = 0; e_done = 0; e_err = 0;
      e_after_rst = 1'b1;
    end else begin
      e_cmd = 15; e_rdy = 0; e_done = 0;
      case (m_mode)
        0: begin
          if (load_start) begin
            e_err = 0; m_idx = 0; m_mode = 1;
          end else if (dump_start) begin
            m_idx = 0; m_mode = 2; m_phase = 0; e_cmd = 1; e_sel = 0;
          end
        end
        1: begin
          if (in_valid) begin
            d = int'(in_data);
            e_rdy = 1; e_cmd = 0; e_sel = m_idx;
            e_cdata = (d <= 9) ? d : 0;
            if (d > 9) e_err = 1;
            m_mem[m_idx] = e_cdata;
            if (m_idx == N - 1) begin m_mode = 0; e_done = 1; end
            else m_idx++;
          end
        end
        default: begin
          if (m_phase == 0) m_phase = 1;
          else if (m_phase == 1) begin
            e_ov = 1; e_od = rd_value(m_idx); e_ol = (m_idx == N - 1); m_phase = 2;
          end else if (out_ready) begin
            e_ov = 0;
            if (m_idx == N - 1) begin m_mode = 0; e_done = 1; end
            else begin m_idx++; m_phase = 0; e_cmd = 1; e_sel = m_idx; end
          end
        end
      endcase
    end
    e_busy = (m_mode != 0);
  endtask

  // Compare every cycle on the falling edge, then advance the model with
  // the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_ready", int'(o_in_ready), int'(m_mode == 1));
      chk("cell_cmd", int'(o_cell_cmd), e_cmd);
      chk("cell_data_rdy", int'(o_cell_data_rdy), int'(e_rdy));
      if (e_cmd != 15 || e_after_rst) chk("cell_sel", int'(o_cell_sel), e_sel);
      if (e_rdy || e_after_rst) chk("cell_data", int'(o_cell_data), e_cdata);
      chk("out_valid", int'(o_out_valid), int'(e_ov));
      if (e_ov || e_after_rst) begin
        chk("out_data", int'(o_out_data), e_od);
        chk("out_last", int'(o_out_last), int'(e_ol));
      end
      chk("busy", int'(o_busy), int'(e_busy));
      chk("done", int'(o_done), int'(e_done));
      chk("err", int'(o_err), int'(e_err));
      if (o_cell_data_rdy) n_strobe++;
      if (o_cell_cmd == 4'h1) n_rd++;
      if (o_done) n_done++;
    end
    model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] beat_data(input int pat, input int i);
    if (pat == 0) return 4'(i % 10);
    if (pat == 1) return (i == 5) ? 4'hC : 4'(i % 10);
    return 4'($urandom_range(11, 0));
  endfunction

  task automatic clear_counts();
    n_strobe = 0; n_rd = 0; n_done = 0;
  endtask

  // Streams stop_at beats; with both_start, dump_start rides along with
  // load_start and then toggles randomly during the load.
  task automatic do_load(input int pat, input int vprob, input int stop_at,
                         input bit both_start);
    int acc, cyc;
    acc = 0; cyc = 0;
    load_start = 1'b1;
    dump_start = both_start;
    step();
    load_start = 1'b0;
    dump_start = 1'b0;
    while (acc < stop_at && cyc < 2000) begin
      in_valid = ($urandom_range(99, 0) < vprob);
      in_data  = beat_data(pat, acc);
      if (both_start) dump_start = 1'($urandom_range(1, 0));
      if (in_valid && o_in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    dump_start = 1'b0;
    chk("load_beats", acc, stop_at);
  endtask

  task automatic do_dump(input int hold_beat, input int rprob, output int ncyc);
    int beat, hold;
    beat = 0; hold = 0; ncyc = 0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    while (!o_done && ncyc < 3000) begin
      if (o_out_valid && beat == hold_beat && hold < 10) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = ($urandom_range(99, 0) < rprob);
      end
      if (o_out_valid && out_ready) beat++;
      step();
      ncyc++;
    end
    out_ready = 1'b0;
    chk("dump_beats", beat, N);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_cmd_nop", int'(o_cell_cmd), 15);
    chk("reset_in_ready", int'(o_in_ready), 0);
    rst = 1'b0;
    step();

    // Full in-order load of i%10
    clear_counts();
    do_load(0, 100, N, 1'b0);
    repeat (3) step();
    chk("t1_strobes", n_strobe, 81);
    chk("t1_done_count", n_done, 1);
    chk("t1_err", int'(o_err), 0);
    chk("t1_cell37", int'(cmem[37]), 7);
    chk("t1_cell80", int'(cmem[80]), 0);

    // Dump with cells answering idx+1, consumer always ready
    rd_mode = 1'b1;
    clear_counts();
    do_dump(-1, 100, ncyc);
    chk("t3_cycles", ncyc, 243);
    step();
    chk("t3_done_count", n_done, 1);
    chk("t3_reads", n_rd, 81);

    // Consumer stalls 10 cycles on beat 7
    clear_counts();
    do_dump(7, 100, ncyc);
    chk("t4_cycles", ncyc, 253);
    chk("t4_reads", n_rd, 81);
    step();

    // Out-of-range digit at index 5; err survives the dump
    rd_mode = 1'b0;
    do_load(1, 80, N, 1'b0);
    repeat (2) step();
    chk("t2_err_after_load", int'(o_err), 1);
    chk("t2_cell5", int'(cmem[5]), 0);
    chk("t2_cell6", int'(cmem[6]), 6);
    do_dump(-1, 60, ncyc);
    step();
    chk("t2_err_after_dump", int'(o_err), 1);

    // Simultaneous starts: LOAD wins, dump_start ignored while busy
    clear_counts();
    do_load(0, 90, N, 1'b1);
    repeat (2) step();
    chk("t6_reads_during_load", n_rd, 0);
    chk("t6_err_cleared", int'(o_err), 0);

    // Reset after beat 40, then restart from cell 0
    do_load(2, 100, 41, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_in_ready", int'(o_in_ready), 0);
    chk("t5_busy", int'(o_busy), 0);
    chk("t5_cmd", int'(o_cell_cmd), 15);
    step();
    clear_counts();
    do_load(2, 70, N, 1'b0);
    repeat (2) step();
    chk("t5_strobes", n_strobe, 81);
    do_dump(-1, 50, ncyc);
    step();

    // Randomized rounds
    for (int r = 0; r < 3; r++) begin
      rd_mode = 1'($urandom_range(1, 0));
      do_load(2, 40 + 20 * r, N, 1'($urandom_range(1, 0)));
      repeat ($urandom_range(3, 1)) step();
      do_dump(int'($urandom_range(80, 0)), 30 + 30 * r, ncyc);
      repeat ($urandom_range(3, 1)) step();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
